mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the core's single SRAM-like memory port between the fetch stage (instruction reads) and the memory stage (data reads/writes).
- Allows one outstanding transaction at a time.
- Fixed data-over-instruction priority.
- Drops instruction read data that returns after a pipeline flush, so fetch never sees stale words. Fetch derives its port-ready/stall request from inst_addr_ok.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width (wstrb width = DATA_W/8)

Ports:
clk  in  1  clock
resetn  in  1  reset
inst_req  in  1  fetch read request, held until inst_addr_ok
inst_addr  in  ADDR_W  fetch address
inst_cancel  in  1  flush: discard any in-flight or pending instruction access
inst_addr_ok  out  1  fetch request accepted (1-cycle pulse)
inst_data_ok  out  1  instruction word valid (1-cycle pulse)
inst_rdata  out  DATA_W  instruction word
data_req  in  1  data request, held until data_addr_ok
data_wr  in  1  1 = write
data_size  in  2  0 = byte, 1 = half, 2 = word
data_addr  in  ADDR_W  data address
data_wdata  in  DATA_W  write data
data_wstrb  in  DATA_W/8  byte enables
data_addr_ok  out  1  data request accepted (pulse)
data_data_ok  out  1  read data valid / write done (pulse)
data_rdata  out  DATA_W  read data
mem_req  out  1  port request
mem_wr  out  1  port write
mem_size  out  2  port size
mem_addr  out  ADDR_W  port address
mem_wdata  out  DATA_W  port write data
mem_wstrb  out  DATA_W/8  port byte enables
mem_addr_ok  in  1  port accepted address
mem_data_ok  in  1  port response valid
mem_rdata  in  DATA_W  port read data

Behaviour:
- Reset: resetn, synchronous, active-low; clock clk.
  - State IDLE, owner = none, drop = 0.
  - All mem_* outputs are 0. All *_addr_ok and *_data_ok outputs are 0. inst_rdata and data_rdata are 0.
  - Reset mid-transaction abandons it; the port is reset alongside.
- FSM states: IDLE, ADDR, RESP.
- IDLE:
  - If data_req: data_addr_ok = 1 (combinational). Latch wr/size/addr/wdata/wstrb into the payload register. Owner = DATA. Go to ADDR.
  - Else if inst_req && !inst_cancel: inst_addr_ok = 1. Latch the address; wr = 0, size = 2, wstrb = 0. Owner = INST. Go to ADDR.
  - inst_req with inst_cancel in the same cycle is not accepted.
- ADDR:
  - mem_req = 1; mem_* driven from the payload register and held stable.
  - On mem_addr_ok: go to RESP, mem_req = 0 in RESP.
- RESP:
  - On mem_data_ok: go to IDLE.
  - If owner = DATA: data_data_ok = 1, data_rdata = mem_rdata in the same cycle.
  - If owner = INST and !drop and !inst_cancel: inst_data_ok = 1, inst_rdata = mem_rdata.
- Drop handling:
  - inst_cancel while owner = INST in ADDR or RESP sets drop.
  - The transaction still completes on the port; no inst_data_ok is issued.
  - drop clears on entry to IDLE.
  - inst_cancel coincident with mem_data_ok also suppresses inst_data_ok.
  - inst_cancel has no effect on a DATA-owned transaction.
- Latency: request accepted in cycle N → mem_req in cycle N+1. Minimum turnaround is 3 cycles (accept, addr, resp), so the earliest next accept is in the IDLE cycle after mem_data_ok.
- rdata outputs are zero whenever the matching *_data_ok is 0.
- mem_data_ok outside RESP is ignored.
- mem_addr_ok outside ADDR is ignored.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined:
  - A last_owner flag (reset = INST) is added.
  - When both requesters are eligible in IDLE, the one not equal to last_owner wins.
  - last_owner updates on each accept.
  - This prevents fetch starvation under back-to-back data traffic.
- Undefined: fixed data-over-instruction priority as above.

Test Plan:
1. After reset, inst_req = 1 addr 0x1C000000. Expect:
   - inst_addr_ok in cycle 1; mem_req = 1, mem_addr = 0x1C000000, mem_wr = 0, mem_size = 2 in cycle 2.
   - Stimulus: mem_addr_ok in cycle 2, mem_data_ok with rdata 0x02800C04 in cycle 4.
   - Required response: inst_data_ok = 1, inst_rdata = 0x02800C04 in cycle 4.
2. data_req (wr = 1, addr 0x80001000, wdata 0xDEADBEEF, wstrb 0xF) and inst_req in the same cycle:
   - data_addr_ok = 1 and inst_addr_ok = 0.
   - mem_wr = 1 with the data payload.
   - inst is accepted in the IDLE cycle after mem_data_ok.
   - With ARB_ROUND_ROBIN_EN, a second tie goes to inst.
3. inst transaction in RESP, inst_cancel pulses 1 cycle, then mem_data_ok 2 cycles later → inst_data_ok stays 0; FSM returns to IDLE; the next inst_req is accepted normally.
4. inst_cancel coincident with mem_data_ok for an inst transaction → no inst_data_ok.
5. inst_cancel during a data read (addr 0x80002000, mem_rdata 0x12345678) → data_data_ok = 1 with 0x12345678, unaffected.
6. mem_addr_ok held low 5 cycles → mem_req and mem_addr stay stable; resetn = 0 during ADDR → mem_req = 0 on the next edge, state IDLE, no *_data_ok issued.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//
// Shares one SRAM-like memory port between the fetch stage (instruction
// reads) and the memory stage (data reads/writes). Only one transaction is
// in flight at a time. The data side has fixed priority over fetch.
// Instruction read data that returns after a flush is dropped, so fetch
// never sees stale words.
//
// Optional build macro:
//   ARB_ROUND_ROBIN_EN - on a tie in IDLE, the requester that did not win
//                        the previous accept is granted. This prevents
//                        fetch starvation under back-to-back data traffic.
//
// Handshake contract (same on every side):
//   - A requester holds *_req and its payload stable until *_addr_ok pulses.
//   - *_addr_ok is a combinational, single-cycle acceptance in IDLE.
//   - *_data_ok pulses for one cycle with read data, or with write completion.
//   - mem_req stays high with a stable payload until mem_addr_ok. The port
//     then returns exactly one mem_data_ok.
//
// Ports:
//   clk, resetn          clock; synchronous active-low reset
//   inst_*               fetch read channel (req/addr/cancel in; addr_ok,
//                        data_ok, rdata out)
//   data_*               data channel (req/wr/size/addr/wdata/wstrb in;
//                        addr_ok, data_ok, rdata out)
//   mem_*                shared memory port (request payload out;
//                        addr_ok, data_ok, rdata in)
//
// Debug visibility: the FSM state register is state_q and the transaction
// owner is owner_q.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                inst_req,
  input  logic [ADDR_W-1:0]   inst_addr,
  input  logic                inst_cancel,
  output logic                inst_addr_ok,
  output logic                inst_data_ok,
  output logic [DATA_W-1:0]   inst_rdata,
  input  logic                data_req,
  input  logic                data_wr,
  input  logic [1:0]          data_size,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  input  logic [DATA_W/8-1:0] data_wstrb,
  output logic                data_addr_ok,
  output logic                data_data_ok,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                mem_req,
  output logic                mem_wr,
  output logic [1:0]          mem_size,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic                mem_addr_ok,
  input  logic                mem_data_ok,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_DATA = 2'd1,
    OWN_INST = 2'd2
  } owner_t;

  state_t state_q, state_d;
  owner_t owner_q, owner_d;
  logic   drop_q,  drop_d;

  // The payload register holds the accepted request while it is on the port.
  logic              pay_wr_q;
  logic [1:0]        pay_size_q;
  logic [ADDR_W-1:0] pay_addr_q;
  logic [DATA_W-1:0] pay_wdata_q;
  logic [STRB_W-1:0] pay_wstrb_q;

  logic grant_data;
  logic grant_inst;
  logic inst_eligible;
  logic pick_data;
  logic resp_fire;

  // A fetch request that arrives together with a flush is never accepted.
  assign inst_eligible = inst_req && !inst_cancel;

`ifdef ARB_ROUND_ROBIN_EN
  owner_t last_owner_q;

  // On a tie, the requester that lost the previous accept wins.
  always_comb begin
    pick_data = data_req;
    if (data_req && inst_eligible) begin
      pick_data = (last_owner_q == OWN_INST);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      last_owner_q <= OWN_INST;
    end else if (grant_data) begin
      last_owner_q <= OWN_DATA;
    end else if (grant_inst) begin
      last_owner_q <= OWN_INST;
    end
  end
`else
  always_comb begin
    pick_data = data_req;
  end
`endif

  assign resp_fire = resetn && (state_q == RESP) && mem_data_ok;

  // Next-state logic and the grant decision.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    drop_d     = drop_q;
    grant_data = 1'b0;
    grant_inst = 1'b0;

    case (state_q)
      IDLE: begin
        if (resetn) begin
          if (pick_data) begin
            grant_data = 1'b1;
            owner_d    = OWN_DATA;
            state_d    = ADDR;
          end else if (inst_eligible) begin
            grant_inst = 1'b1;
            owner_d    = OWN_INST;
            state_d    = ADDR;
          end
        end
      end
      ADDR: begin
        if (mem_addr_ok) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (mem_data_ok) begin
          state_d = IDLE;
          owner_d = OWN_NONE;
        end
      end
      default: begin
        state_d = IDLE;
        owner_d = OWN_NONE;
      end
    endcase

    // A flush during an in-flight fetch lets the port transaction finish.
    // The returning word is discarded.
    if ((owner_q == OWN_INST) && (state_q != IDLE) && inst_cancel) begin
      drop_d = 1'b1;
    end
    if (state_d == IDLE) begin
      drop_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= IDLE;
      owner_q     <= OWN_NONE;
      drop_q      <= 1'b0;
      pay_wr_q    <= 1'b0;
      pay_size_q  <= 2'd0;
      pay_addr_q  <= '0;
      pay_wdata_q <= '0;
      pay_wstrb_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      drop_q  <= drop_d;
      if (grant_data) begin
        pay_wr_q    <= data_wr;
        pay_size_q  <= data_size;
        pay_addr_q  <= data_addr;
        pay_wdata_q <= data_wdata;
        pay_wstrb_q <= data_wstrb;
      end else if (grant_inst) begin
        pay_wr_q    <= 1'b0;
        pay_size_q  <= 2'd2;
        pay_addr_q  <= inst_addr;
        pay_wdata_q <= '0;
        pay_wstrb_q <= '0;
      end
    end
  end

  // Port outputs are driven only while a request is on the port.
  // They read as zero at every other time.
  always_comb begin
    mem_req   = 1'b0;
    mem_wr    = 1'b0;
    mem_size  = 2'd0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    if (state_q == ADDR) begin
      mem_req   = 1'b1;
      mem_wr    = pay_wr_q;
      mem_size  = pay_size_q;
      mem_addr  = pay_addr_q;
      mem_wdata = pay_wdata_q;
      mem_wstrb = pay_wstrb_q;
    end
  end

  // Requester-side responses. The rdata outputs are zero unless valid.
  always_comb begin
    data_addr_ok = grant_data;
    inst_addr_ok = grant_inst;
    data_data_ok = resp_fire && (owner_q == OWN_DATA);
    inst_data_ok = resp_fire && (owner_q == OWN_INST) && !drop_q && !inst_cancel;
    data_rdata   = data_data_ok ? mem_rdata : '0;
    inst_rdata   = inst_data_ok ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//
// Directed testbench for mem_port_arbiter. The bench plays the fetch stage,
// the memory stage and the memory port. Inputs change 1 time unit after each
// rising edge. Outputs are sampled 1 more unit later, well away from the edge.
// The expected values are constants worked out for each step.
module tb_mem_port_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic              clk;
  logic              resetn;
  logic              inst_req;
  logic [ADDR_W-1:0] inst_addr;
  logic              inst_cancel;
  logic              inst_addr_ok;
  logic              inst_data_ok;
  logic [DATA_W-1:0] inst_rdata;
  logic              data_req;
  logic              data_wr;
  logic [1:0]        data_size;
  logic [ADDR_W-1:0] data_addr;
  logic [DATA_W-1:0] data_wdata;
  logic [3:0]        data_wstrb;
  logic              data_addr_ok;
  logic              data_data_ok;
  logic [DATA_W-1:0] data_rdata;
  logic              mem_req;
  logic              mem_wr;
  logic [1:0]        mem_size;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [3:0]        mem_wstrb;
  logic              mem_addr_ok;
  logic              mem_data_ok;
  logic [DATA_W-1:0] mem_rdata;

  int vectors;
  int miscompares;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_cancel  (inst_cancel),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_wstrb   (data_wstrb),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata),
    .mem_req      (mem_req),
    .mem_wr       (mem_wr),
    .mem_size     (mem_size),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_wstrb    (mem_wstrb),
    .mem_addr_ok  (mem_addr_ok),
    .mem_data_ok  (mem_data_ok),
    .mem_rdata    (mem_rdata)
  );

  // Clock generation
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver helpers
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Tie between a data read and a fetch, then completion of the winner.
  task automatic tie(input string tag, input logic exp_data);
    data_req   = 1'b1;
    data_wr    = 1'b0;
    data_size  = 2'd2;
    data_addr  = 32'h8000_3000;
    data_wstrb = 4'hF;
    inst_req   = 1'b1;
    inst_addr  = 32'h1C00_0200;
    settle();
    chk({tag, "_data_addr_ok"}, data_addr_ok, exp_data);
    chk({tag, "_inst_addr_ok"}, inst_addr_ok, !exp_data);
    step();
    data_req    = 1'b0;
    inst_req    = 1'b0;
    mem_addr_ok = 1'b1;
    settle();
    chk({tag, "_mem_addr"}, mem_addr, exp_data ? 32'h8000_3000 : 32'h1C00_0200);
    step();
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b1;
    mem_rdata   = 32'h5A5A_0000;
    settle();
    chk({tag, "_data_data_ok"}, data_data_ok, exp_data);
    chk({tag, "_inst_data_ok"}, inst_data_ok, !exp_data);
    step();
    mem_data_ok = 1'b0;
    mem_rdata   = '0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    resetn      = 1'b0;
    inst_req    = 1'b0;
    inst_addr   = '0;
    inst_cancel = 1'b0;
    data_req    = 1'b1;
    data_wr     = 1'b0;
    data_size   = 2'd0;
    data_addr   = '0;
    data_wdata  = '0;
    data_wstrb  = '0;
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b0;
    mem_rdata   = '0;

    // Reset: data_req is already active, but nothing may be granted.
    step();
    step();
    settle();
    chk("rst_data_addr_ok", data_addr_ok, 1'b0);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wstrb", mem_wstrb, 4'h0);
    chk("rst_inst_rdata", inst_rdata, 32'h0);
    chk("rst_data_rdata", data_rdata, 32'h0);
    data_req = 1'b0;

    // 1: basic fetch
    resetn    = 1'b1;
    inst_req  = 1'b1;
    inst_addr = 32'h1C00_0000;
    settle();
    chk("t1_inst_addr_ok", inst_addr_ok, 1'b1);
    chk("t1_mem_req_c1", mem_req, 1'b0);
    step();
    inst_req    = 1'b0;
    mem_addr_ok = 1'b1;
    settle();
    chk("t1_mem_req", mem_req, 1'b1);
    chk("t1_mem_addr", mem_addr, 32'h1C00_0000);
    chk("t1_mem_wr", mem_wr, 1'b0);
    chk("t1_mem_size", mem_size, 2'd2);
    chk("t1_mem_wstrb", mem_wstrb, 4'h0);
    step();
    mem_addr_ok = 1'b0;
    settle();
    chk("t1_mem_req_c3", mem_req, 1'b0);
    chk("t1_inst_data_ok_c3", inst_data_ok, 1'b0);
    step();
    mem_data_ok = 1'b1;
    mem_rdata   = 32'h0280_0C04;
    settle();
    chk("t1_inst_data_ok", inst_data_ok, 1'b1);
    chk("t1_inst_rdata", inst_rdata, 32'h0280_0C04);
    step();
    mem_data_ok = 1'b0;
    settle();
    chk("t1_inst_data_ok_c5", inst_data_ok, 1'b0);
    chk("t1_inst_rdata_c5", inst_rdata, 32'h0);

    // 2: data write and fetch requested together; data wins.
    step();
    data_req   = 1'b1;
    data_wr    = 1'b1;
    data_size  = 2'd2;
    data_addr  = 32'h8000_1000;
    data_wdata = 32'hDEAD_BEEF;
    data_wstrb = 4'hF;
    inst_req   = 1'b1;
    inst_addr  = 32'h1C00_0004;
    settle();
    chk("t2_data_addr_ok", data_addr_ok, 1'b1);
    chk("t2_inst_addr_ok", inst_addr_ok, 1'b0);
    step();
    data_req    = 1'b0;
    data_wr     = 1'b0;
    mem_addr_ok = 1'b1;
    settle();
    chk("t2_mem_req", mem_req, 1'b1);
    chk("t2_mem_wr", mem_wr, 1'b1);
    chk("t2_mem_addr", mem_addr, 32'h8000_1000);
    chk("t2_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    chk("t2_mem_wstrb", mem_wstrb, 4'hF);
    chk("t2_inst_wait_addr", inst_addr_ok, 1'b0);
    step();
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b1;
    settle();
    chk("t2_data_data_ok", data_data_ok, 1'b1);
    chk("t2_inst_wait_resp", inst_addr_ok, 1'b0);
    step();
    mem_data_ok = 1'b0;
    settle();
    chk("t2_inst_accept", inst_addr_ok, 1'b1);
    chk("t2_data_data_ok_idle", data_data_ok, 1'b0);
    step();
    inst_req    = 1'b0;
    mem_addr_ok = 1'b1;
    settle();
    chk("t2_inst_mem_addr", mem_addr, 32'h1C00_0004);
    chk("t2_inst_mem_wr", mem_wr, 1'b0);
    step();
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b1;
    mem_rdata   = 32'h1111_2222;
    settle();
    chk("t2_inst_data_ok", inst_data_ok, 1'b1);
    chk("t2_inst_rdata", inst_rdata, 32'h1111_2222);
    step();
    mem_data_ok = 1'b0;
    mem_rdata   = '0;

    // Two more ties. The round-robin build hands the second one to fetch.
    tie("t2_tie1", 1'b1);
`ifdef ARB_ROUND_ROBIN_EN
    tie("t2_tie2", 1'b0);
`else
    tie("t2_tie2", 1'b1);
`endif

    // 3: flush pulse in RESP, response 2 cycles later, dropped.
    inst_req  = 1'b1;
    inst_addr = 32'h1C00_0010;
    settle();
    chk("t3_inst_addr_ok", inst_addr_ok, 1'b1);
    step();
    inst_req    = 1'b0;
    mem_addr_ok = 1'b1;
    step();
    mem_addr_ok = 1'b0;
    inst_cancel = 1'b1;
    settle();
    chk("t3_cancel_cycle", inst_data_ok, 1'b0);
    step();
    inst_cancel = 1'b0;
    step();
    mem_data_ok = 1'b1;
    mem_rdata   = 32'hBAD0_BAD0;
    settle();
    chk("t3_dropped_ok", inst_data_ok, 1'b0);
    chk("t3_dropped_rdata", inst_rdata, 32'h0);
    step();
    mem_data_ok = 1'b0;
    inst_req    = 1'b1;
    inst_addr   = 32'h1C00_0020;
    settle();
    chk("t3_next_accept", inst_addr_ok, 1'b1);
    step();
    inst_req    = 1'b0;
    mem_addr_ok = 1'b1;
    settle();
    chk("t3_next_mem_addr", mem_addr, 32'h1C00_0020);
    step();
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b1;
    mem_rdata   = 32'h3333_4444;
    settle();
    chk("t3_next_data_ok", inst_data_ok, 1'b1);
    chk("t3_next_rdata", inst_rdata, 32'h3333_4444);
    step();
    mem_data_ok = 1'b0;

    // 4: flush coincident with the response
    inst_req  = 1'b1;
    inst_addr = 32'h1C00_0030;
    settle();
    chk("t4_inst_addr_ok", inst_addr_ok, 1'b1);
    step();
    inst_req    = 1'b0;
    mem_addr_ok = 1'b1;
    step();
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b1;
    mem_rdata   = 32'h5555_6666;
    inst_cancel = 1'b1;
    settle();
    chk("t4_inst_data_ok", inst_data_ok, 1'b0);
    chk("t4_inst_rdata", inst_rdata, 32'h0);
    step();
    mem_data_ok = 1'b0;
    inst_cancel = 1'b0;

    // 5: a flush does not affect a data read
    data_req  = 1'b1;
    data_wr   = 1'b0;
    data_size = 2'd2;
    data_addr = 32'h8000_2000;
    settle();
    chk("t5_data_addr_ok", data_addr_ok, 1'b1);
    step();
    data_req    = 1'b0;
    inst_cancel = 1'b1;
    mem_addr_ok = 1'b1;
    settle();
    chk("t5_mem_addr", mem_addr, 32'h8000_2000);
    chk("t5_mem_wr", mem_wr, 1'b0);
    step();
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b1;
    mem_rdata   = 32'h1234_5678;
    settle();
    chk("t5_data_data_ok", data_data_ok, 1'b1);
    chk("t5_data_rdata", data_rdata, 32'h1234_5678);
    chk("t5_inst_data_ok", inst_data_ok, 1'b0);
    step();
    mem_data_ok = 1'b0;
    inst_cancel = 1'b0;
    mem_rdata   = '0;

    // 6: port stalls the address, then reset lands in ADDR.
    inst_req  = 1'b1;
    inst_addr = 32'h1C00_0100;
    settle();
    chk("t6_inst_addr_ok", inst_addr_ok, 1'b1);
    step();
    inst_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      settle();
      chk("t6_stall_mem_req", mem_req, 1'b1);
      chk("t6_stall_mem_addr", mem_addr, 32'h1C00_0100);
      step();
    end
    resetn = 1'b0;
    settle();
    chk("t6_rst_inst_data_ok", inst_data_ok, 1'b0);
    step();
    settle();
    chk("t6_rst_mem_req", mem_req, 1'b0);
    chk("t6_rst_mem_addr", mem_addr, 32'h0);
    chk("t6_rst_data_data_ok", data_data_ok, 1'b0);
    chk("t6_rst_inst_data_ok2", inst_data_ok, 1'b0);
    // A stale response arriving in IDLE is ignored. Fetch is accepted at once.
    resetn      = 1'b1;
    mem_data_ok = 1'b1;
    mem_rdata   = 32'hFFFF_FFFF;
    inst_req    = 1'b1;
    inst_addr   = 32'h1C00_0200;
    settle();
    chk("t6_stale_data_ok", inst_data_ok, 1'b0);
    chk("t6_stale_rdata", inst_rdata, 32'h0);
    chk("t6_idle_accept", inst_addr_ok, 1'b1);
    step();
    inst_req    = 1'b0;
    mem_data_ok = 1'b0;
    mem_addr_ok = 1'b1;
    settle();
    chk("t6_mem_addr", mem_addr, 32'h1C00_0200);
    step();
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b1;
    mem_rdata   = 32'h0BAD_F00D;
    settle();
    chk("t6_inst_data_ok", inst_data_ok, 1'b1);
    chk("t6_inst_rdata", inst_rdata, 32'h0BAD_F00D);
    step();
    mem_data_ok = 1'b0;
    mem_rdata   = '0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
